// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM encoding, default sizes and counter width for adder_rr_arbiter.
package adder_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = 16;
endpackage

// File: rtl/adder_rr_grant.sv
// adder_rr_grant: one-hot round-robin grant from a thermometer mask, plus the mask for the next round.
module adder_rr_grant #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [NREQ-1:0] mask_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] mask_o
);
  logic [NREQ-1:0] masked, pool;
  always_comb begin
    masked = valid_i & mask_i;
    pool = |masked ? masked : valid_i;
    gnt_o = pool & (~pool + NREQ'(1));
    // a grant to the top index shifts out to zero, leaving an all-zero mask
    mask_o = ~((gnt_o << 1) - NREQ'(1));
  end
endmodule

// File: rtl/csa_adder.sv
// csa_adder: a + b + cin via one carry-save compression stage and a final carry-propagate add.
module csa_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   sum_o
);
  logic [WIDTH-1:0] c0, s, c;
  always_comb begin
    c0 = {{(WIDTH-1){1'b0}}, cin_i};
    s = a_i ^ b_i ^ c0;
    c = (a_i & b_i) | (a_i & c0) | (b_i & c0);
    sum_o = {1'b0, s} + {c, 1'b0};
  end
endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one csa_adder among NREQ requesters.
// Defining ADDER_ARB_CNT_EN adds the op_cnt response counter output.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NREQ-1:0]       rsp_id,
  output logic [WIDTH:0]        rsp_sum,
`ifdef ADDER_ARB_CNT_EN
  output logic [CNT_W-1:0]      op_cnt,
`endif
  output logic                  busy
);
  state_t state_q, state_d;
  logic [NREQ-1:0] mask_q, mask_d, id_q, id_d, gnt, nmask;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sel_a, sel_b;
  logic cin_q, cin_d, sel_cin, vld_q, vld_d;
  logic [WIDTH:0] sum_q, sum_d, add_sum;
  adder_rr_grant #(.NREQ(NREQ)) u_grant (
    .valid_i(req_valid),
    .mask_i (mask_q),
    .gnt_o  (gnt),
    .mask_o (nmask)
  );
  csa_adder #(.WIDTH(WIDTH)) u_add (
    .a_i  (a_q),
    .b_i  (b_q),
    .cin_i(cin_q),
    .sum_o(add_sum)
  );
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a = sel_a | (gnt[i] ? req_a[i*WIDTH +: WIDTH] : '0);
      sel_b = sel_b | (gnt[i] ? req_b[i*WIDTH +: WIDTH] : '0);
      sel_cin = sel_cin | (gnt[i] & req_cin[i]);
    end
  end
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    sum_d = sum_q;
    vld_d = vld_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = CALC;
        mask_d = nmask;
        id_d = gnt;
        a_d = sel_a;
        b_d = sel_b;
        cin_d = sel_cin;
      end
      CALC: begin
        state_d = RESP;
        sum_d = add_sum;
        vld_d = 1'b1;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        vld_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        vld_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
    end
  end
`ifdef ADDER_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (vld_q && rsp_ready) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign op_cnt = cnt_q;
`endif
  // grant is gated by reset so held requests never see a ready while in reset
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
  assign rsp_valid = vld_q;
  assign rsp_id = id_q;
  assign rsp_sum = sum_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: scoreboard bench for adder_rr_arbiter with directed operand vectors.
module tb_adder_rr_arbiter;
  typedef struct packed {
    logic [3:0] id;
    logic [8:0] sum;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_cin = '0, req_ready, rsp_id;
  logic [31:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_ready = 1'b1, busy;
  logic [8:0] rsp_sum;
`ifdef ADDER_ARB_CNT_EN
  logic [15:0] op_cnt;
`endif
  exp_t q[$];
  int checks = 0, errors = 0, hs = 0, hs_base = 0;
  adder_rr_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_cin(req_cin),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_sum(rsp_sum),
`ifdef ADDER_ARB_CNT_EN
    .op_cnt(op_cnt),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_cin[i] = c;
  endtask
  task automatic push(input logic [3:0] id, input logic [8:0] sum);
    q.push_back('{id, sum});
  endtask
  task automatic drain(input string name);
    for (int k = 0; k < 200 && q.size() != 0; k++) cyc();
    chk(name, q.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef ADDER_ARB_CNT_EN
    chk({tag, "_op_cnt"}, op_cnt, 0);
`endif
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    hs_base = hs;
    cyc();
    cyc();
    @(negedge clk);
    chk_zero("reset");
    cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && rsp_valid && rsp_ready) begin
            hs++;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_rsp: got id %b sum %0d expected no response", rsp_id, rsp_sum);
            end else begin
              e = q.pop_front();
              chk("rsp_id", rsp_id, e.id);
              chk("rsp_sum", rsp_sum, e.sum);
            end
          end
        end
      end
    join_none
    do_reset();
    // single request: grant, CALC, RESP, back to IDLE
    set_op(0, 10, 20, 0);
    req_valid = 4'b0001;
    push(4'b0001, 9'd30);
    @(negedge clk);
    chk("t1_grant", req_ready, 4'b0001);
    chk("t1_idle_busy", busy, 0);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("t1_calc_busy", busy, 1);
    chk("t1_calc_vld", rsp_valid, 0);
    chk("t1_calc_ready", req_ready, 0);
    cyc();
    @(negedge clk);
    chk("t1_resp_vld", rsp_valid, 1);
    chk("t1_resp_busy", busy, 1);
    cyc();
    @(negedge clk);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_vld", rsp_valid, 0);
    // all four requesting: order 0,1,2,3 then wrap to 0
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(22 + i), 11, 1);
    push(4'b0001, 9'd34);
    push(4'b0010, 9'd35);
    push(4'b0100, 9'd36);
    push(4'b1000, 9'd37);
    push(4'b0001, 9'd34);
    req_valid = 4'b1111;
    drain("t2_drain");
    req_valid = '0;
    // 1 and 3: mask picks 1, then 3, then fallback to 1
    set_op(1, 5, 6, 0);
    set_op(3, 100, 50, 1);
    push(4'b0010, 9'd11);
    push(4'b1000, 9'd151);
    push(4'b0010, 9'd11);
    req_valid = 4'b1010;
    drain("t3_drain");
    req_valid = '0;
    // back-pressure with requester 0 also waiting
    set_op(2, 43, 27, 1);
    set_op(0, 1, 2, 0);
    rsp_ready = 1'b0;
    push(4'b0100, 9'd71);
    push(4'b0001, 9'd3);
    req_valid = 4'b0101;
    for (int k = 0; k < 20 && !rsp_valid; k++) cyc();
    chk("t4_wait_rsp", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_vld", rsp_valid, 1);
      chk("t4_hold_sum", rsp_sum, 71);
      chk("t4_hold_id", rsp_id, 4'b0100);
      chk("t4_hold_ready", req_ready, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    drain("t4_drain");
    req_valid = '0;
    // overflow into the carry-out bit
    set_op(3, 255, 255, 1);
    push(4'b1000, 9'd511);
    req_valid = 4'b1000;
    drain("t5_drain");
    req_valid = '0;
    // reset during CALC discards the operation
    set_op(1, 1, 1, 0);
    req_valid = 4'b0010;
    for (int k = 0; k < 20 && !(busy && !rsp_valid); k++) cyc();
    chk("t6_in_calc", busy && !rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    hs_base = hs;
    #1;
    chk_zero("t6_abort");
    cyc();
    rst_n = 1'b1;
    set_op(3, 9, 9, 0);
    req_valid = 4'b1010;
    push(4'b0010, 9'd2);
    push(4'b1000, 9'd18);
    @(negedge clk);
    chk("t6_first_grant", req_ready, 4'b0010);
    drain("t6_drain");
    req_valid = '0;
    cyc();
`ifdef ADDER_ARB_CNT_EN
    @(negedge clk);
    chk("op_cnt", op_cnt, 32'(hs - hs_base));
`endif
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
